// File: rtl/fb_spi_writer.sv
// SPI-slave framebuffer writer: SET writes one cell, FILL sweeps the whole buffer.
// Ports: pixel_clk/rst_n (sync, active-low); spi_sclk/spi_mosi/spi_cs_n in (async);
//        spi_miso=busy; wr_en/wr_x/wr_y/wr_data write port; busy fill flag; err sticky.
//        Define FB_SPI_AUTOINC_EN to let further colour pairs after a SET
//        write successive cells.
module fb_spi_writer #(
  parameter int FB_W = 160,
  parameter int FB_H = 100
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  output logic        wr_en,
  output logic [7:0]  wr_x,
  output logic [6:0]  wr_y,
  output logic [14:0] wr_data,
  output logic        busy,
  output logic        err
);

  localparam logic [8:0] FB_W9  = 9'(FB_W);
  localparam logic [7:0] FB_H8  = 8'(FB_H);
  localparam logic [7:0] LAST_X = 8'(FB_W - 1);
  localparam logic [6:0] LAST_Y = 7'(FB_H - 1);

  typedef enum logic [3:0] {
    IDLE, SET_X, SET_Y, SET_HI, SET_LO,
    FILL_HI, FILL_LO, FILLING, DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic        sclk_m_q, sclk_s_q, sclk_p_q;
  logic        mosi_m_q, mosi_s_q;
  logic        cs_m_q, cs_s_q, cs_p_q;
  logic [1:0]  live_q, live_d;
  logic        armed_q, armed_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [6:0]  hi_q, hi_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_x_q, wr_x_d;
  logic [6:0]  wr_y_q, wr_y_d;
  logic [14:0] wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic        sclk_rise, cs_fall, byte_done, set_ok;
  logic        fill_last;
  logic [7:0]  rx;

`ifdef FB_SPI_AUTOINC_EN
  logic [7:0]  nx, ny;
  always_comb begin
    nx = x_q + 8'd1;
    ny = y_q;
    if ({1'b0, x_q} + 9'd1 >= FB_W9) begin
      nx = 8'd0;
      ny = (y_q + 8'd1 >= FB_H8) ? 8'd0 : y_q + 8'd1;
    end
  end
`endif

  assign sclk_rise = sclk_s_q & ~sclk_p_q;
  assign cs_fall   = ~cs_s_q & cs_p_q;
  assign rx        = {shift_q, mosi_s_q};
  assign set_ok    = ({1'b0, x_q} < FB_W9) && (y_q < FB_H8);
  assign fill_last = (wr_x_q == LAST_X) && (wr_y_q == LAST_Y);

  always_comb begin
    state_d   = state_q;
    live_d    = (live_q == 2'd2) ? live_q : live_q + 2'd1;
    armed_d   = armed_q | ((live_q == 2'd2) & cs_s_q);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    x_d       = x_q;
    y_d       = y_q;
    hi_d      = hi_q;
    wr_en_d   = 1'b0;
    wr_x_d    = wr_x_q;
    wr_y_d    = wr_y_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    err_d     = err_q;
    byte_done = 1'b0;

    if (cs_fall) err_d = 1'b0;

    // Fill engine: the current write position lives in wr_x/wr_y.
    if (busy_q) begin
      if (fill_last) begin
        busy_d = 1'b0;
        if (state_q == FILLING) state_d = DRAIN;
      end else begin
        wr_en_d = 1'b1;
        if (wr_x_q == LAST_X) begin
          wr_x_d = 8'd0;
          wr_y_d = wr_y_q + 7'd1;
        end else begin
          wr_x_d = wr_x_q + 8'd1;
        end
      end
    end

    // Until cs_n is seen high after reset, the link is treated as deselected.
    if (cs_s_q || !armed_q) begin
      bit_cnt_d = 3'd0;
      shift_d   = 7'd0;
      state_d   = IDLE;
    end else if (sclk_rise) begin
      shift_d   = rx[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      byte_done = (bit_cnt_q == 3'd7);
    end

    if (byte_done) begin
      if (busy_q) begin
        err_d = 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            unique case (1'b1)
              (rx == 8'h01): state_d = SET_X;
              (rx == 8'h02): state_d = FILL_HI;
              default: begin
                state_d = DRAIN;
                err_d   = 1'b1;
              end
            endcase
          end
          SET_X: begin
            x_d     = rx;
            state_d = SET_Y;
          end
          SET_Y: begin
            y_d     = rx;
            state_d = SET_HI;
          end
          SET_HI: begin
            hi_d    = rx[6:0];
            state_d = SET_LO;
          end
          SET_LO: begin
            if (set_ok) begin
              wr_en_d   = 1'b1;
              wr_x_d    = x_q;
              wr_y_d    = y_q[6:0];
              wr_data_d = {hi_q, rx};
`ifdef FB_SPI_AUTOINC_EN
              x_d       = nx;
              y_d       = ny;
              state_d   = SET_HI;
`else
              state_d   = DRAIN;
`endif
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end
          FILL_HI: begin
            hi_d    = rx[6:0];
            state_d = FILL_LO;
          end
          FILL_LO: begin
            busy_d    = 1'b1;
            wr_en_d   = 1'b1;
            wr_x_d    = 8'd0;
            wr_y_d    = 7'd0;
            wr_data_d = {hi_q, rx};
            state_d   = FILLING;
          end
          default: state_d = DRAIN;
        endcase
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sclk_m_q  <= 1'b0;
      sclk_s_q  <= 1'b0;
      sclk_p_q  <= 1'b0;
      mosi_m_q  <= 1'b0;
      mosi_s_q  <= 1'b0;
      cs_m_q    <= 1'b1;
      cs_s_q    <= 1'b1;
      cs_p_q    <= 1'b1;
      live_q    <= 2'd0;
      armed_q   <= 1'b0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 7'd0;
      x_q       <= 8'd0;
      y_q       <= 8'd0;
      hi_q      <= 7'd0;
      wr_en_q   <= 1'b0;
      wr_x_q    <= 8'd0;
      wr_y_q    <= 7'd0;
      wr_data_q <= 15'd0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sclk_m_q  <= spi_sclk;
      sclk_s_q  <= sclk_m_q;
      sclk_p_q  <= sclk_s_q;
      mosi_m_q  <= spi_mosi;
      mosi_s_q  <= mosi_m_q;
      cs_m_q    <= spi_cs_n;
      cs_s_q    <= cs_m_q;
      cs_p_q    <= cs_s_q;
      live_q    <= live_d;
      armed_q   <= armed_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      x_q       <= x_d;
      y_q       <= y_d;
      hi_q      <= hi_d;
      wr_en_q   <= wr_en_d;
      wr_x_q    <= wr_x_d;
      wr_y_q    <= wr_y_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_x     = wr_x_q;
  assign wr_y     = wr_y_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign spi_miso = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fb_spi_writer.sv
// Directed bench for fb_spi_writer: a queue model of expected writes
// is checked against every wr_en cycle; literal checks pin key results.
module tb_fb_spi_writer;

  localparam int W = 160;
  localparam int H = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_sclk, spi_mosi, spi_cs_n;
  logic        spi_miso, wr_en, busy, err;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [14:0] wr_data;

  typedef struct {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [14:0] d;
    logic        fill;
  } wr_t;

  wr_t expq[$];
  int  total = 0;
  int  bad = 0;
  int  fill_seen = 0;

  fb_spi_writer #(.FB_W(W), .FB_H(H)) dut (
    .pixel_clk(clk), .rst_n(rst_n),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Model: a SET yields one write when in range, else no write and an error.
  function automatic bit model_set(input int x, input int y, input int hi, input int lo);
    wr_t e;
    if (x >= W || y >= H) return 1'b1;
    e.x = 8'(x); e.y = 7'(y); e.d = 15'((hi % 128) * 256 + lo); e.fill = 1'b0;
    expq.push_back(e);
    return 1'b0;
  endfunction

  function automatic void model_fill(input int hi, input int lo);
    wr_t e;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        e.x = 8'(x); e.y = 7'(y); e.d = 15'((hi % 128) * 256 + lo); e.fill = 1'b1;
        expq.push_back(e);
      end
  endfunction

  always @(negedge clk) begin
    wr_t e;
    total++;
    if (spi_miso !== busy) begin
      bad++;
      $display("FAIL miso_eq_busy got=%0b exp=%0b", spi_miso, busy);
    end
    if (wr_en) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL stray_write got=(%0d,%0d,%0h) exp=none", wr_x, wr_y, wr_data);
      end else begin
        e = expq.pop_front();
        if (wr_x !== e.x || wr_y !== e.y || wr_data !== e.d || busy !== e.fill) begin
          bad++;
          $display("FAIL write got=(%0d,%0d,%0h,b%0b) exp=(%0d,%0d,%0h,b%0b)",
                   wr_x, wr_y, wr_data, busy, e.x, e.y, e.d, e.fill);
        end
        if (e.fill) fill_seen++;
      end
    end else if (busy) begin
      total++;
      bad++;
      $display("FAIL fill_gap got=wr_en0 exp=wr_en1");
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      tick(4);
      spi_sclk = 1'b1;
      tick(4);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    spi_bits(b, 8);
  endtask

  task automatic cs_lo();
    spi_cs_n = 1'b0;
    tick(6);
  endtask

  task automatic cs_hi();
    tick(6);
    spi_cs_n = 1'b1;
    tick(8);
  endtask

  task automatic wait_q_empty(input int bound);
    int n = 0;
    while (expq.size() != 0 && n < bound) begin
      tick(1);
      n++;
    end
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL write_timeout got=%0d exp=0", expq.size());
      expq.delete();
    end
  endtask

  task automatic send_set(input int x, input int y, input int hi, input int lo);
    cs_lo();
    spi_byte(8'h01); spi_byte(8'(x)); spi_byte(8'(y));
    spi_byte(8'(hi)); spi_byte(8'(lo));
    cs_hi();
  endtask

  initial begin
    bit e_err;
    rst_n = 1'b0; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
    tick(4);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_xy", {wr_x, wr_y}, 0);
    check("rst_data", 32'(wr_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    tick(4);

    e_err = model_set(5, 3, 8'h7C, 8'h00);
    send_set(5, 3, 8'h7C, 8'h00);
    wait_q_empty(50);
    check("set_x", 32'(wr_x), 5);
    check("set_y", 32'(wr_y), 3);
    check("set_data", 32'(wr_data), 32'h7C00);
    check("set_err", 32'(err), 32'(e_err));

    e_err = model_set(8'hA0, 0, 8'h7F, 8'hFF);
    send_set(8'hA0, 0, 8'h7F, 8'hFF);
    check("range_x_err", 32'(err), 32'(e_err));
    check("range_x_held", 32'(wr_data), 32'h7C00);
    cs_lo();
    check("err_clear", 32'(err), 0);
    cs_hi();

    cs_lo();
    spi_byte(8'h33);
    spi_byte(8'h01); spi_byte(8'h05); spi_byte(8'h03);
    spi_byte(8'h7C); spi_byte(8'h00);
    cs_hi();
    check("bad_op_err", 32'(err), 1);

    cs_lo();
    spi_byte(8'h01);
    spi_bits(8'h05, 3);
    cs_hi();
    e_err = model_set(10, 7, 8'h92, 8'h34);
    send_set(10, 7, 8'h92, 8'h34);
    wait_q_empty(50);
    check("abort_data", 32'(wr_data), 32'h1234);
    check("abort_err", 32'(err), 32'(e_err));

    e_err = model_set(W - 1, H - 1, 8'h01, 8'h02);
    send_set(W - 1, H - 1, 8'h01, 8'h02);
    wait_q_empty(50);
    check("corner_xy", {wr_x, wr_y}, {8'd159, 7'd99});
    e_err = model_set(0, H, 8'h01, 8'h02);
    send_set(0, H, 8'h01, 8'h02);
    check("range_y_err", 32'(err), 32'(e_err));

    e_err = model_set(W - 1, 2, 8'h00, 8'h01);
`ifdef FB_SPI_AUTOINC_EN
    e_err = model_set(0, 3, 8'h00, 8'h02);
`endif
    cs_lo();
    spi_byte(8'h01); spi_byte(8'h9F); spi_byte(8'h02);
    spi_byte(8'h00); spi_byte(8'h01);
    spi_byte(8'h00); spi_byte(8'h02);
    cs_hi();
    wait_q_empty(50);
    check("auto_err", 32'(err), 0);

    fill_seen = 0;
    model_fill(8'h00, 8'h1F);
    cs_lo();
    spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'h1F);
    cs_hi();
    check("fill_busy", 32'(busy), 1);
    cs_lo();
    spi_byte(8'h01); spi_byte(8'h05); spi_byte(8'h03);
    spi_byte(8'h7C); spi_byte(8'h00);
    cs_hi();
    check("busy_byte_err", 32'(err), 1);
    check("busy_still", 32'(busy), 1);
    wait_q_empty(20000);
    tick(2);
    check("fill_count", fill_seen, W * H);
    check("fill_done_busy", 32'(busy), 0);
    check("fill_last_xy", {wr_x, wr_y}, {8'd159, 7'd99});
    check("fill_data", 32'(wr_data), 32'h001F);
    cs_lo();
    check("fill_err_clear", 32'(err), 0);
    cs_hi();

    fill_seen = 0;
    model_fill(8'h03, 8'hE0);
    cs_lo();
    spi_byte(8'h02); spi_byte(8'h03); spi_byte(8'hE0);
    cs_hi();
    begin
      int n = 0;
      while (fill_seen < 500 && n < 2000) begin
        @(negedge clk);
        #2;
        n++;
      end
    end
    check("fill_reached_500", 32'(fill_seen >= 500), 1);
    rst_n = 1'b0;
    expq.delete();
    @(posedge clk);
    #1;
    check("mid_rst_wr_en", 32'(wr_en), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_out", {wr_x, wr_y, wr_data}, 0);
    tick(3);
    rst_n = 1'b1;
    tick(6);
    check("post_rst_idle", 32'(wr_en), 0);

    e_err = model_set(1, 1, 8'h00, 8'h05);
    send_set(1, 1, 8'h00, 8'h05);
    wait_q_empty(50);
    check("post_rst_data", 32'(wr_data), 32'h0005);
    check("post_rst_err", 32'(err), 32'(e_err));

    tick(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_spi_writer.md
FB_SPI_WRITER -- requirements
Module: fb_spi_writer

Interface
REQ-001 SHALL have parameter FB_W, default 160, framebuffer width in cells.
REQ-002 SHALL have parameter FB_H, default 100, framebuffer height in cells.
REQ-003 SHALL have port pixel_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port spi_sclk  in  1  host SPI clock, asynchronous to pixel_clk.
REQ-006 SHALL have port spi_mosi  in  1  host data, mode 0, MSB first.
REQ-007 SHALL have port spi_cs_n  in  1  host chip select, active-low, asynchronous.
REQ-008 SHALL have port spi_miso  out  1  equals busy.
REQ-009 SHALL have port wr_en  out  1  one-cycle framebuffer write strobe.
REQ-010 SHALL have port wr_x  out  8  write column.
REQ-011 SHALL have port wr_y  out  7  write row.
REQ-012 SHALL have port wr_data  out  15  write colour {r5,g5,b5}.
REQ-013 SHALL have port busy  out  1  high while a fill sweep runs.
REQ-014 SHALL have port err  out  1  sticky protocol/range error flag.

Function
REQ-015 SHALL pass spi_sclk, spi_mosi, spi_cs_n through 2-flop synchronizers; supported when spi_sclk period >= 4 pixel_clk periods.
REQ-016 SHALL sample mosi on each synchronized sclk rising edge while synced cs_n low; 8 samples form a byte, MSB first.
REQ-017 SHALL, on synced cs_n high, clear bit and byte counters, discard any partial byte or incomplete command, and return the FSM to IDLE (a running fill continues).
REQ-018 SHALL clear err on each synced cs_n falling edge.
REQ-019 FSM states: IDLE, SET_X, SET_Y, SET_HI, SET_LO, FILL_HI, FILL_LO, FILLING, DRAIN.
REQ-020 IDLE: opcode 0x01 -> SET_X; 0x02 -> FILL_HI; any other -> DRAIN with err set.
REQ-021 SET: bytes x, y, colour_hi (bit 7 ignored), colour_lo; on the cycle after the last bit of colour_lo is sampled, wr_en SHALL be high for exactly one cycle with wr_x=x, wr_y=y[6:0], wr_data={hi[6:0],lo}; then DRAIN.
REQ-022 SET with x >= FB_W or y >= FB_H SHALL produce no write and set err.
REQ-023 FILL: bytes colour_hi, colour_lo, then FILLING; busy rises the cycle after colour_lo completes.
REQ-024 FILLING SHALL write one cell per cycle, y outer 0..FB_H-1, x inner 0..FB_W-1, FB_W*FB_H consecutive wr_en cycles; busy falls the cycle after the last write (x=FB_W-1, y=FB_H-1).
REQ-025 Bytes completed while busy SHALL be discarded with err set; FILLING continues regardless of cs_n.
REQ-026 DRAIN SHALL ignore all bytes until cs_n high.
REQ-027 wr_en SHALL be low in every cycle not defined above; wr_x/wr_y/wr_data hold their last value when wr_en low.

Reset
REQ-028 rst_n low at a clock edge SHALL force: FSM IDLE, counters 0, fill aborted, wr_en=0, wr_x=0, wr_y=0, wr_data=0, busy=0, spi_miso=0, err=0, synchronizers to idle (cs_n=1, sclk=0, mosi=0).
REQ-029 Reset mid-command or mid-fill SHALL discard it; the first command after release requires a fresh cs_n falling edge.

Configuration
REQ-030 Macro FB_SPI_AUTOINC_EN defined: after a valid SET write, each further 2-byte colour pair within the same cs_n low SHALL write at the next cell (x+1; at FB_W wrap x to 0 and y+1; at FB_H wrap y to 0), one wr_en per pair.
REQ-031 FB_SPI_AUTOINC_EN undefined: bytes after a SET command SHALL be ignored (DRAIN) and no extra writes occur.

Verification
REQ-032 SET 01,05,03,7C,00 -> single wr_en, wr_x=5, wr_y=3, wr_data=0x7C00, err=0.
REQ-033 SET 01,A0,00,7F,FF -> no wr_en, err=1; next cs_n falling edge -> err=0.
REQ-034 FILL 02,00,1F -> busy high, 16000 consecutive wr_en with wr_data=0x001F, first (0,0), last (159,99), then busy low.
REQ-035 cs_n high after 3 bits of x in a SET -> no write; new SET then writes correctly.
REQ-036 rst_n low at fill write 500 -> next cycle wr_en=0, busy=0, outputs 0.
REQ-037 With FB_SPI_AUTOINC_EN: 01,9F,02,00,01,00,02 -> writes (159,2)=0x0001 then (0,3)=0x0002; without macro: only first write.
